// File: rtl/obm_dma_if.sv
// Bus bundle for the OBM DMA engine: source-RAM read port plus the VRAM write
// port that fills Object Memory.
interface obm_dma_if #(
    parameter int VRAM_ADDR_WIDTH = 12
);
    logic                       src_rd;
    logic [15:0]                src_addr;
    logic [7:0]                 src_data;
    logic [VRAM_ADDR_WIDTH-1:0] vram_address;
    logic [7:0]                 vram_data;
    logic                       write_enable;
    logic                       SELECT_obm;

    modport master (
        output src_rd,
        output src_addr,
        input  src_data,
        output vram_address,
        output vram_data,
        output write_enable,
        output SELECT_obm
    );

    modport slave (
        input  src_rd,
        input  src_addr,
        output src_data,
        input  vram_address,
        input  vram_data,
        input  write_enable,
        input  SELECT_obm
    );
endinterface

// File: rtl/obm_dma.sv
// OBM DMA: copies NUM_OBJECTS*4 bytes from a CPU RAM page into Object Memory,
// one fetch/store pair per byte, issuing fetches only while the write window is open.
module obm_dma #(
    parameter int                         VRAM_ADDR_WIDTH = 12,
    parameter int                         NUM_OBJECTS     = 64,
    parameter logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE        = 12'h800
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       src_page,
    input  logic             allow,
    obm_dma_if.master        bus,
    output logic             busy,
    output logic             done
);

    localparam int         XFER_LEN = NUM_OBJECTS * 4;
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [7:0]                 idx_r;
    logic [7:0]                 idx_s;
    logic [7:0]                 page_r;
    logic [7:0]                 page_s;

    logic                       src_rd_s;
    logic [15:0]                src_addr_s;
    logic [VRAM_ADDR_WIDTH-1:0] vram_address_s;
    logic [7:0]                 vram_data_s;
    logic                       write_enable_s;
    logic                       busy_s;
    logic                       done_s;

    // State, byte index and latched source page
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 8'd0;
            page_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            page_r  <= page_s;
        end
    end

    // Next-state and bus strobes; read data is forwarded straight into the
    // STORE cycle because the source RAM answers exactly one cycle after src_rd.
    always_comb begin
        state_s        = state_r;
        idx_s          = idx_r;
        page_s         = page_r;
        src_rd_s       = 1'b0;
        src_addr_s     = 16'h0000;
        vram_address_s = {VRAM_ADDR_WIDTH{1'b0}};
        vram_data_s    = 8'h00;
        write_enable_s = 1'b0;
        busy_s         = 1'b1;
        done_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    page_s  = src_page;
                    idx_s   = 8'd0;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (allow) begin
                    src_rd_s   = 1'b1;
                    src_addr_s = {page_r, idx_r};
                    state_s    = ST_STORE;
                end else begin
                    state_s    = ST_FETCH;
                end
            end
            ST_STORE: begin
                // The store finishes regardless of allow: its data is already on the bus.
                write_enable_s = 1'b1;
                vram_address_s = OBM_BASE + VRAM_ADDR_WIDTH'(idx_r);
                vram_data_s    = bus.src_data;
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = idx_r + 8'd1;
                    state_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.src_rd       = src_rd_s;
    assign bus.src_addr     = src_addr_s;
    assign bus.vram_address = vram_address_s;
    assign bus.vram_data    = vram_data_s;
    assign bus.write_enable = write_enable_s;
    assign bus.SELECT_obm   = write_enable_s;
    assign busy             = busy_s;
    assign done             = done_s;

endmodule
